// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester arbiter and access sequencer for the shared
// external memory port. Each grant runs an ACCESS phase of exactly ACC_CYC
// cycles with the strobe held high. A DONE cycle then pulses the winner's ack.
// Optional feature macro: MEM_PORT_ARB_RR_EN.
//   Defined:   on a tie, round-robin between the CPU and the panel.
//   Undefined: fixed priority, so the CPU always wins a tie.
module mem_port_arb #(
   parameter int ACC_CYC = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              pnl_req,
   input  logic              pnl_we,
   input  logic [ADDR_W-1:0] pnl_addr,
   input  logic [DATA_W-1:0] pnl_wdata,
   output logic              pnl_ack,
   output logic [DATA_W-1:0] pnl_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din,
   output logic              mem_read,
   output logic              mem_write,
   output logic              busy,
   output logic              owner
);

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                cmd_we;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic                owner_q;
   logic                grant_any;
   logic                grant_pnl;

   // Arbitration: decide which requester wins if a grant happens this cycle.
   always_comb begin
      grant_any = cpu_req | pnl_req;
`ifdef MEM_PORT_ARB_RR_EN
      // On a tie, the requester that did not win the last grant goes next.
      grant_pnl = pnl_req & (~cpu_req | ~owner_q);
`else
      grant_pnl = pnl_req & ~cpu_req;
`endif
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registers take non-blocking assignments so that every flop
      // samples values from before the edge.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: requests are looked at only in IDLE.
   always_comb begin
      // NOTE: the default is assigned first so that no path leaves state_nxt
      // unassigned, which would infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, cycle counter, owner tracking and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         owner_q   <= 1'b1;
         cpu_rdata <= '0;
         pnl_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_q   <= grant_pnl;
                  cmd_we    <= grant_pnl ? pnl_we    : cpu_we;
                  cmd_addr  <= grant_pnl ? pnl_addr  : cpu_addr;
                  cmd_wdata <= grant_pnl ? pnl_wdata : cpu_wdata;
                  cnt       <= CNT_W'(ACC_CYC - 1);
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!cmd_we) begin
                  // The last access cycle captures the read data for the owner only.
                  if (owner_q) pnl_rdata <= mem_din;
                  else         cpu_rdata <= mem_din;
               end
            end
            default: ;
         endcase
      end
   end

   // All outputs decode registered state only, so req has no combinational path to the strobes.
   assign busy      = (state != IDLE);
   assign owner     = owner_q;
   assign mem_addr  = cmd_addr;
   assign mem_read  = (state == ACCESS) & ~cmd_we;
   assign mem_write = (state == ACCESS) &  cmd_we;
   assign mem_dout  = mem_write ? cmd_wdata : '0;
   assign cpu_ack   = (state == DONE) & ~owner_q;
   assign pnl_ack   = (state == DONE) &  owner_q;

endmodule
